// File: rtl/riscv_defines.sv
// Shared encodings for the RV32I-subset cores: FSM states, opcodes, ALU ops
// and datapath mux selects.
package riscv_defines;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_RS1   = 2'd1;
  localparam logic [1:0] SRC_A_OLDPC = 2'd2;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_FOUR = 2'd1;
  localparam logic [1:0] SRC_B_IMM  = 2'd2;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

endpackage

// File: rtl/alu_control.sv
// Combinational funct3/funct7 decode to the 4-bit ALU op; shared with the
// single-cycle core.
module alu_control
  import riscv_defines::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       is_rtype,
  output logic [3:0] alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      3'b000:  alu_op = (funct7_5 && is_rtype) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_op = ALU_SLT;
      3'b110:  alu_op = ALU_OR;
      3'b111:  alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I-subset control FSM: sequences fetch/decode/execute/mem/wb
// and drives datapath enables, mux selects and the ALU op from the state.
module multicycle_control
  import riscv_defines::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       alu_zero,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [3:0] alu_operation,
  output logic       retire
);

  state_t     state;
  logic       is_rtype;
  logic [3:0] ctl_op;

  // Branch gating on alu_zero happens in the datapath; the port is kept for
  // interface compatibility only.
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;

  assign is_rtype = (state == S_EXEC_R);

  alu_control u_alu_control (
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .is_rtype (is_rtype),
    .alu_op   (ctl_op)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= state_t'(RESET_STATE);
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: state <= S_MEM_ADDR;
            OP_RTYPE:          state <= S_EXEC_R;
            OP_ITYPE:          state <= S_EXEC_I;
            OP_BRANCH:         state <= S_BRANCH;
            OP_JAL:            state <= S_JAL;
            default:           state <= S_FETCH;
          endcase
        end
        S_MEM_ADDR:  state <= (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  state <= S_MEM_WB;
        S_EXEC_R:    state <= S_ALU_WB;
        S_EXEC_I:    state <= S_ALU_WB;
        default:     state <= S_FETCH;
      endcase
    end
  end

  // Outputs are gated by reset directly so an aborted instruction cannot
  // write the RF or memory in the cycle reset is sampled.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    pc_source     = PC_SRC_ALU;
    alu_operation = ALU_ADD;
    retire        = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          ir_write  = 1'b1;
          alu_src_a = SRC_A_PC;
          alu_src_b = SRC_B_FOUR;
          pc_source = PC_SRC_ALU;
          pc_write  = 1'b1;
        end
        S_DECODE: begin
          alu_src_a = SRC_A_OLDPC;
          alu_src_b = SRC_B_IMM;
          case (opcode)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: retire = 1'b0;
            default: retire = 1'b1;
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          retire    = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a     = SRC_A_RS1;
          alu_src_b     = SRC_B_RS2;
          alu_operation = ctl_op;
        end
        S_EXEC_I: begin
          alu_src_a     = SRC_A_RS1;
          alu_src_b     = SRC_B_IMM;
          alu_operation = ctl_op;
        end
        S_ALU_WB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = SRC_A_RS1;
          alu_src_b     = SRC_B_RS2;
          alu_operation = ALU_SUB;
          pc_source     = PC_SRC_ALUOUT;
          pc_write_cond = 1'b1;
          retire        = 1'b1;
        end
        S_JAL: begin
          reg_write = 1'b1;
          pc_source = PC_SRC_JUMP;
          pc_write  = 1'b1;
          retire    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle control vectors for each
// instruction class, reset behaviour and mid-instruction abort.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       alu_zero;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_write, retire;
  logic [1:0] alu_src_a, alu_src_b, pc_source;
  logic [3:0] alu_operation;

  int unsigned checks = 0;
  int unsigned errors = 0;

  multicycle_control #(.RESET_STATE(4'd0)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7_5      (funct7_5),
    .alu_zero      (alu_zero),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_source     (pc_source),
    .alu_operation (alu_operation),
    .retire        (retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [18:0] obs;
  assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source,
                alu_operation, retire};

  function automatic logic [18:0] ctl(
    input logic pcw, pcwc, iord, mr, mw, irw, m2r, rw,
    input logic [1:0] sa, sb, ps,
    input logic [3:0] op,
    input logic ret);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rw, sa, sb, ps, op, ret};
  endfunction

  task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-derived control vectors per state
  logic [18:0] v_reset, v_fetch, v_dec, v_dec_nop, v_maddr, v_mrd, v_mwb, v_mwr;
  logic [18:0] v_alu_wb, v_branch, v_jal;
  logic [18:0] exp_q[$];

  task automatic run(input string name, input logic [6:0] opc, input logic [2:0] f3,
                     input logic f7, input logic z);
    opcode   = opc;
    funct3   = f3;
    funct7_5 = f7;
    alu_zero = z;
    foreach (exp_q[i]) begin
      check($sformatf("%s_c%0d", name, i + 1), obs, exp_q[i]);
      step();
    end
    check($sformatf("%s_back_fetch", name), obs, v_fetch);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    v_reset   = ctl(0,0,0,0,0,0,0,0, 2'd0,2'd0,2'd0, 4'b0010, 0);
    v_fetch   = ctl(1,0,0,1,0,1,0,0, 2'd0,2'd1,2'd0, 4'b0010, 0);
    v_dec     = ctl(0,0,0,0,0,0,0,0, 2'd2,2'd2,2'd0, 4'b0010, 0);
    v_dec_nop = ctl(0,0,0,0,0,0,0,0, 2'd2,2'd2,2'd0, 4'b0010, 1);
    v_maddr   = ctl(0,0,0,0,0,0,0,0, 2'd1,2'd2,2'd0, 4'b0010, 0);
    v_mrd     = ctl(0,0,1,1,0,0,0,0, 2'd0,2'd0,2'd0, 4'b0010, 0);
    v_mwb     = ctl(0,0,0,0,0,0,1,1, 2'd0,2'd0,2'd0, 4'b0010, 1);
    v_mwr     = ctl(0,0,1,0,1,0,0,0, 2'd0,2'd0,2'd0, 4'b0010, 1);
    v_alu_wb  = ctl(0,0,0,0,0,0,0,1, 2'd0,2'd0,2'd0, 4'b0010, 1);
    v_branch  = ctl(0,1,0,0,0,0,0,0, 2'd1,2'd0,2'd1, 4'b0110, 1);
    v_jal     = ctl(1,0,0,0,0,0,0,1, 2'd0,2'd0,2'd2, 4'b0010, 1);

    reset = 1'b1; opcode = '0; funct3 = '0; funct7_5 = 1'b0; alu_zero = 1'b0;
    step();
    check("reset_c1", obs, v_reset);
    step();
    check("reset_c2", obs, v_reset);
    reset = 1'b0;
    #1;
    check("reset_release_fetch", obs, v_fetch);

    exp_q = '{v_fetch, v_dec, ctl(0,0,0,0,0,0,0,0, 2'd1,2'd0,2'd0, 4'b0110, 0), v_alu_wb};
    run("r_sub", 7'b0110011, 3'b000, 1'b1, 1'b0);
    exp_q = '{v_fetch, v_dec, ctl(0,0,0,0,0,0,0,0, 2'd1,2'd0,2'd0, 4'b0010, 0), v_alu_wb};
    run("r_add", 7'b0110011, 3'b000, 1'b0, 1'b0);
    exp_q = '{v_fetch, v_dec, ctl(0,0,0,0,0,0,0,0, 2'd1,2'd0,2'd0, 4'b0111, 0), v_alu_wb};
    run("r_slt", 7'b0110011, 3'b010, 1'b0, 1'b0);
    exp_q = '{v_fetch, v_dec, ctl(0,0,0,0,0,0,0,0, 2'd1,2'd0,2'd0, 4'b0000, 0), v_alu_wb};
    run("r_and", 7'b0110011, 3'b111, 1'b1, 1'b0);
    exp_q = '{v_fetch, v_dec, ctl(0,0,0,0,0,0,0,0, 2'd1,2'd0,2'd0, 4'b0010, 0), v_alu_wb};
    run("r_f3_101", 7'b0110011, 3'b101, 1'b1, 1'b0);

    exp_q = '{v_fetch, v_dec, v_maddr, v_mrd, v_mwb};
    run("lw", 7'b0000011, 3'b010, 1'b0, 1'b0);
    exp_q = '{v_fetch, v_dec, v_maddr, v_mwr};
    run("sw", 7'b0100011, 3'b010, 1'b0, 1'b0);

    exp_q = '{v_fetch, v_dec, v_branch};
    run("beq_z1", 7'b1100011, 3'b000, 1'b0, 1'b1);
    exp_q = '{v_fetch, v_dec, v_branch};
    run("beq_z0", 7'b1100011, 3'b000, 1'b0, 1'b0);

    exp_q = '{v_fetch, v_dec, ctl(0,0,0,0,0,0,0,0, 2'd1,2'd2,2'd0, 4'b0001, 0), v_alu_wb};
    run("ori", 7'b0010011, 3'b110, 1'b1, 1'b0);
    exp_q = '{v_fetch, v_dec, ctl(0,0,0,0,0,0,0,0, 2'd1,2'd2,2'd0, 4'b0010, 0), v_alu_wb};
    run("addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0);

    exp_q = '{v_fetch, v_dec, v_jal};
    run("jal", 7'b1101111, 3'b000, 1'b0, 1'b0);
    exp_q = '{v_fetch, v_dec_nop};
    run("nop", 7'b0000000, 3'b000, 1'b0, 1'b0);

    // lw aborted by reset while in MEM_READ
    opcode = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0;
    check("abort_c1", obs, v_fetch);
    step();
    check("abort_c2", obs, v_dec);
    step();
    check("abort_c3", obs, v_maddr);
    step();
    check("abort_c4", obs, v_mrd);
    reset = 1'b1;
    #1;
    check("abort_during_reset", obs, v_reset);
    step();
    reset = 1'b0;
    #1;
    check("abort_next_fetch", obs, v_fetch);
    step();
    check("abort_then_decode", obs, v_dec);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
